// File: rtl/fp_muldiv_seq_if.sv
// fp_muldiv_seq_if: operand/result valid-ready bundle for fp_muldiv_seq.
// master = issue/writeback side, slave = the unit.
interface fp_muldiv_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  localparam int W = EXP_W + MAN_W + 1;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_muldiv_seq.sv
// fp_muldiv_seq: multi-cycle FP mul/div (shift-add / restoring), RTZ, FTZ.
// Ports: clk, rst_n (async low), bus (slave: a,b,op in; result,flags out).
module fp_muldiv_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_muldiv_seq_if.slave bus
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int M  = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(M + 2);

  localparam logic signed [EW-1:0] BIAS = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] EZ   = '0;
  localparam logic [CW-1:0] LAST_MUL = CW'(M - 1);
  localparam logic [CW-1:0] LAST_DIV = CW'(M);

  localparam logic [W-2:0] INF  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] ZERO = '0;
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
  state_t state, nxt;

  logic               sa, sb, s;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               za, zb, ia, ib, na, nb;
  logic signed [EW-1:0] xa, xb;

  assign {sa, ea, fa} = bus.a;
  assign {sb, eb, fb} = bus.b;
  assign s  = sa ^ sb;
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (&ea) && (fa == '0);
  assign ib = (&eb) && (fb == '0);
  assign na = (&ea) && (fa != '0);
  assign nb = (&eb) && (fb != '0);
  assign xa = $signed({2'b00, ea});
  assign xb = $signed({2'b00, eb});

  logic               op_r, sgn_r;
  logic [M-1:0]       ma_r, mb_r;
  logic signed [EW-1:0] exp_r;
  logic [2*M-1:0]     p;
  logic [M:0]         r, q;
  logic [CW-1:0]      cnt;
  logic [W-1:0]       res_r;
  logic [3:0]         flg_r;

  logic               spec;
  logic [W-1:0]       sp_res;
  logic [3:0]         sp_flg;

  // Specials in priority order; denormals already count as zero.
  always_comb begin
    spec   = 1'b1;
    sp_res = '0;
    sp_flg = '0;
    if (na || nb ||
        (bus.op ? ((za && zb) || (ia && ib))
                : ((za && ib) || (ia && zb)))) begin
      sp_res = QNAN;
      sp_flg = 4'b1000;
    end else if (bus.op && zb && !ia) begin
      sp_res = {s, INF};
      sp_flg = 4'b0100;
    end else if (ia || (!bus.op && ib)) begin
      sp_res = {s, INF};
    end else if (za || zb || ib) begin
      sp_res = {s, ZERO};
    end else begin
      spec = 1'b0;
    end
  end

  logic [M:0]   sum;
  logic         ge;
  logic [M-1:0] diff;

  always_comb begin
    sum  = {1'b0, p[2*M-1:M]} + (p[0] ? {1'b0, ma_r} : '0);
    ge   = (r >= {1'b0, mb_r});
    diff = ge ? (r[M-1:0] - mb_r) : r[M-1:0];
  end

  logic               hi;
  logic [MAN_W-1:0]   frac;
  logic signed [EW-1:0] e_n;
  logic [W-1:0]       n_res;
  logic [3:0]         n_flg;

  always_comb begin
    hi = op_r ? q[M] : p[2*M-1];
    if (op_r) begin
      frac = hi ? q[M-1 -: MAN_W] : q[M-2 -: MAN_W];
      e_n  = hi ? exp_r : exp_r - ONE;
    end else begin
      frac = hi ? p[2*M-2 -: MAN_W] : p[2*M-3 -: MAN_W];
      e_n  = hi ? exp_r + ONE : exp_r;
    end
    n_res = {sgn_r, e_n[EXP_W-1:0], frac};
    n_flg = '0;
    if (e_n >= EMAX) begin
      n_res = {sgn_r, INF};
      n_flg = 4'b0010;
    end else if (e_n <= EZ) begin
      n_res = {sgn_r, ZERO};
      n_flg = 4'b0001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid) nxt = spec ? DONE : CALC;
      CALC: if (cnt == (op_r ? LAST_DIV : LAST_MUL)) nxt = NORM;
      NORM: nxt = DONE;
      DONE: if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r  <= 1'b0;
      sgn_r <= 1'b0;
      ma_r  <= '0;
      mb_r  <= '0;
      exp_r <= '0;
      p     <= '0;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
      res_r <= '0;
      flg_r <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          if (spec) begin
            res_r <= sp_res;
            flg_r <= sp_flg;
          end else begin
            op_r  <= bus.op;
            sgn_r <= s;
            ma_r  <= {1'b1, fa};
            mb_r  <= {1'b1, fb};
            exp_r <= bus.op ? xa - xb + BIAS : xa + xb - BIAS;
            // low half holds the multiplier, shifted out LSB first
            p     <= {{M{1'b0}}, 1'b1, fb};
            r     <= {2'b01, fa};
            q     <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_r) begin
            r <= {diff, 1'b0};
            q <= {q[M-1:0], ge};
          end else begin
            p <= {sum, p[M-1:1]};
          end
        end
        NORM: begin
          res_r <= n_res;
          flg_r <= n_flg;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_r;
  assign bus.flags     = flg_r;
endmodule

// File: tb/tb_fp_muldiv_seq.sv
// tb_fp_muldiv_seq: directed + random checks of fp_muldiv_seq (binary32)
// against an integer-arithmetic reference model.
module tb_fp_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fp_muldiv_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_muldiv_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // 0 zero/denormal, 1 normal, 2 inf, 3 nan
  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'd0) return 0;
    if (x[30:23] != 8'hff) return 1;
    return (x[22:0] == 23'd0) ? 2 : 3;
  endfunction

  function automatic void model(input bit op, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] res,
                                output logic [3:0] flg, output int lat);
    int ca, cb, e2, k, be;
    bit s;
    longint unsigned ma, mb, v;
    ca = cls(a);
    cb = cls(b);
    s = a[31] ^ b[31];
    flg = 4'd0;
    lat = 1;
    res = 32'd0;
    if (ca == 3 || cb == 3 ||
        (!op && ((ca == 0 && cb == 2) || (ca == 2 && cb == 0))) ||
        (op && ca == cb && (ca == 0 || ca == 2))) begin
      res = 32'h7fc00000;
      flg = 4'b1000;
    end else if (op && ca == 1 && cb == 0) begin
      res = {s, 31'h7f800000};
      flg = 4'b0100;
    end else if (ca == 2 || (!op && cb == 2)) begin
      res = {s, 31'h7f800000};
    end else if (ca == 0 || cb == 0 || cb == 2) begin
      res = {s, 31'd0};
    end else begin
      lat = op ? 27 : 26;
      ma = 64'h800000 | 64'(a[22:0]);
      mb = 64'h800000 | 64'(b[22:0]);
      if (!op) begin
        v  = ma * mb;
        e2 = int'(a[30:23]) + int'(b[30:23]) - 254 - 46;
      end else begin
        v  = (ma << 24) / mb;
        e2 = int'(a[30:23]) - int'(b[30:23]) - 24;
      end
      k = 0;
      for (int i = 63; i >= 0; i--)
        if (v[i]) begin
          k = i;
          break;
        end
      be = e2 + k + 127;
      if (be >= 255) begin
        res = {s, 31'h7f800000};
        flg = 4'b0010;
      end else if (be <= 0) begin
        res = {s, 31'd0};
        flg = 4'b0001;
      end else begin
        v = v >> (k - 23);
        res = {s, 8'(be), v[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_fp();
    int c;
    logic [31:0] f;
    logic [7:0] e;
    c = $urandom_range(0, 15);
    f = $urandom;
    if (c == 0) e = 8'd0;
    else if (c == 1) begin
      e = 8'hff;
      if ($urandom_range(0, 1) == 0) f = 32'd0;
    end else e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, f[22:0]};
  endfunction

  task automatic run_op(input bit op, input logic [31:0] a,
                        input logic [31:0] b, input int bp,
                        input bit pre, input string tag);
    logic [31:0] er;
    logic [3:0] ef;
    int el, n;
    model(op, a, b, er, ef, el);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.out_ready = pre;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    n = 1;
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(el));
    chk({tag, "_res"}, 64'(bus.result), 64'(er));
    chk({tag, "_flg"}, 64'(bus.flags), 64'(ef));
    chk({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
    if (!pre) begin
      repeat (bp) begin
        @(negedge clk);
        chk({tag, "_hold"},
            {30'd0, bus.out_valid, bus.in_ready, bus.flags, bus.result},
            {30'd0, 1'b1, 1'b0, ef, er});
      end
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_exit"}, {62'd0, bus.out_valid, bus.in_ready},
        64'b01);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int vseen;
    bus.in_valid = 1'b0;
    bus.op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state",
        {26'd0, bus.in_ready, bus.out_valid, bus.flags, bus.result},
        {26'd0, 1'b1, 1'b0, 4'd0, 32'd0});
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'h40400000, 32'h40200000, 0, 1'b0, "mul3x2.5");
    run_op(1'b1, 32'h3f800000, 32'h40400000, 0, 1'b0, "div1/3");
    run_op(1'b1, 32'h40a00000, 32'h00000000, 0, 1'b0, "div5/0");
    run_op(1'b1, 32'hc0a00000, 32'h00000000, 0, 1'b0, "div-5/0");
    run_op(1'b0, 32'h00000000, 32'h7f800000, 0, 1'b0, "mul0xinf");
    run_op(1'b0, 32'h7fc00001, 32'h3f800000, 0, 1'b0, "mulnan");
    run_op(1'b0, 32'h7f000000, 32'h7f000000, 0, 1'b0, "mulovf");
    run_op(1'b0, 32'h00800000, 32'h00800000, 0, 1'b0, "mulunf");
    run_op(1'b0, 32'h00400000, 32'h40000000, 0, 1'b0, "muldenorm");
    run_op(1'b1, 32'h7f800000, 32'h00000000, 0, 1'b0, "divinf/0");
    run_op(1'b1, 32'h40000000, 32'hff800000, 0, 1'b0, "div2/-inf");
    run_op(1'b0, 32'h40400000, 32'h40200000, 5, 1'b0, "bp5");
    run_op(1'b1, 32'h3f800000, 32'h40400000, 0, 1'b1, "b2b_a");
    run_op(1'b0, 32'hc0400000, 32'h40200000, 0, 1'b1, "b2b_b");

    // abort mid-calculation
    bus.in_valid = 1'b1;
    bus.op = 1'b0;
    bus.a = 32'h40400000;
    bus.b = 32'h40200000;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    @(negedge clk);
    rst_n = 1'b1;
    vseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) vseen++;
    end
    chk("rst_novalid", 64'(vseen), 64'd0);
    run_op(1'b0, 32'h40400000, 32'h40200000, 0, 1'b0, "post_rst");

    for (int i = 0; i < 40; i++)
      run_op(1'($urandom), rnd_fp(), rnd_fp(),
             $urandom_range(0, 3), 1'($urandom), "rnd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fp_muldiv_seq.md
Name: fp_muldiv_seq

Overview:
- Parametrised, multi-cycle IEEE 754 multiply/divide unit. It is the sequential successor to the team's combinational single-precision ALU datapath.
- Generic exponent and mantissa widths.
- Shift-add mantissa multiplier and restoring mantissa divider, one bit per cycle.
- valid/ready handshakes on input and output; exception flags.
- Sits between the operand issue logic and the result writeback in the FP pipeline.

Parameters:
EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 23, stored mantissa (fraction) width; M = MAN_W+1 including hidden bit

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  unit can accept; equals (state==IDLE)
op  input  1  0 = a*b, 1 = a/b
a  input  EXP_W+MAN_W+1  operand A (sign, exp, frac)
b  input  EXP_W+MAN_W+1  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  EXP_W+MAN_W+1  packed result
flags  output  4  {invalid, div_by_zero, overflow, underflow}

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, so in_ready=1.
  - out_valid=0, result=0, flags=0.
  - All datapath registers are cleared.
- Reset mid-operation aborts the operation with no output. After release, the first accepted operation is unaffected.
- Accept occurs when in_valid && in_ready (cycle T). The unit latches a, b and op.
- States:
  - IDLE -> CALC on a normal accept; IDLE -> DONE on a special-case accept.
  - CALC runs a counter for M cycles (mul) or M+1 cycles (div), then moves to NORM.
  - NORM lasts 1 cycle, then moves to DONE.
  - DONE holds result/flags and out_valid=1 until out_ready=1, then returns to IDLE. The output is stable under backpressure.
- Latency, out_valid first high at:
  - special case: T+1
  - mul: T+M+2 (T+26 at default)
  - div: T+M+3 (T+27 at default)
- in_ready=0 in CALC, NORM and DONE. There is no accept in the same cycle as output handoff; the next accept is earliest in the cycle after DONE exits.
- Denormal inputs (exp==0) are treated as signed zero (flush-to-zero). Denormal results flush to zero.
- Rounding is round-toward-zero (truncation) for all results.
- Sign = sa ^ sb for all non-NaN results.
- Multiply datapath:
  - Exponent ea+eb-bias, computed in an EXP_W+2-bit signed width.
  - P = ma*mb, 2M bits.
  - If P[2M-1]=1: frac = P[2M-2 -: MAN_W] and exp+1.
  - Else: frac = P[2M-3 -: MAN_W].
- Divide datapath:
  - Exponent ea-eb+bias.
  - Q = floor(ma*2^M / mb), M+1 bits.
  - If Q[M]=1: frac = Q[M-1 -: MAN_W].
  - Else: frac = Q[M-2 -: MAN_W] and exp-1.
- Range checks after normalisation:
  - Biased exp >= 2^EXP_W-1 gives ±inf with overflow=1.
  - Biased exp <= 0 gives ±0 with underflow=1.
- Special cases, in priority order, all bypassing CALC:
  - Any NaN operand, 0*inf, inf*0, 0/0 or inf/inf gives canonical qNaN (sign 0, exp all ones, frac MSB=1, rest 0) with invalid=1.
  - Finite nonzero x/0 gives ±inf with div_by_zero=1.
  - inf*x, or inf/x (x finite) gives ±inf with no flag.
  - x/inf, 0*x or 0/x gives ±0 with no flag.
- Flags are valid only with out_valid. Flags are replaced by the next operation's flags; they are not sticky.

Test Plan:
- Multiply: mul 0x40400000 * 0x40200000 (3.0*2.5) -> result 0x40F00000, flags 0, out_valid at exactly T+26.
- Divide: div 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated), flags 0, out_valid at T+27.
- Special cases:
  - div 0x40A00000 / 0x00000000 -> 0x7F800000 with div_by_zero at T+1.
  - div 0xC0A00000 / 0 -> 0xFF800000.
  - mul 0 * 0x7F800000 -> 0x7FC00000 with invalid.
  - mul with a=0x7FC00001 -> 0x7FC00000 with invalid.
- Range limits:
  - mul 0x7F000000 * 0x7F000000 -> 0x7F800000 with overflow.
  - mul 0x00800000 * 0x00800000 -> 0x00000000 with underflow.
  - mul 0x00400000 (denormal) * 0x40000000 -> 0x00000000, flags 0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable and in_ready=0. Raising out_ready gives handoff, then in_ready=1 next cycle. Back-to-back ops are accepted in order.
- Reset mid-CALC: pulse rst_n low at T+10 -> out_valid stays 0 and in_ready=1 after release. A following mul 3.0*2.5 returns 0x40F00000 at the correct latency.
